// File: rtl/perf_monitor_pkg.sv
// perf_monitor shared types: FSM states, counter select codes, defaults.
// Used by perf_monitor and perf_trace_buf.
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pm_state_t;

  localparam logic [1:0] SEL_CYC = 2'd0;
  localparam logic [1:0] SEL_STL = 2'd1;
  localparam logic [1:0] SEL_FLS = 2'd2;
  localparam logic [1:0] SEL_RET = 2'd3;

  localparam int CNT_W_DEF      = 32;
  localparam int MAX_CYCLES_DEF = 80;

endpackage

// File: rtl/perf_trace_buf.sv
// Circular buffer of retired PCs with a registered read port.
// Index 0 on the read port addresses the most recent entry.
module perf_trace_buf
  import perf_monitor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] ridx_i,
  output logic [31:0]              rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] raddr;

  // wptr points at the next free slot, so newest is wptr-1
  always_comb begin
    raddr = wptr - AW'(1) - ridx_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rdata_o <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rdata_o <= '0;
    end else begin
      if (we_i) begin
        mem[wptr] <= wdata_i;
        wptr      <= wptr + AW'(1);
      end
      rdata_o <= mem[raddr];
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: cycle/stall/flush/retire counters.
// Optional retired-PC trace when PERF_TRACE_EN is defined.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_CYCLES  = MAX_CYCLES_DEF,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  input  logic [1:0]       sel_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic             running_o,
  output logic             done_o
`ifdef PERF_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [31:0]                    trace_pc_o
`endif
);

  localparam int XW = (CNT_W > 32) ? CNT_W : 32;

  pm_state_t        st_q, st_d;
  logic [CNT_W-1:0] cyc_q, stl_q, fls_q, ret_q;
  logic [CNT_W-1:0] cyc_d, stl_d, fls_d, ret_d;
  logic [CNT_W-1:0] rd_d;
  logic             cnt_en;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // a paused window (start low) does not count that cycle
  assign cnt_en = (st_q == ST_RUN) && start_i;

  always_comb begin
    cyc_d = sat_inc(cyc_q, cnt_en);
    stl_d = sat_inc(stl_q, cnt_en && stall_i && !flush_i);
    fls_d = sat_inc(fls_q, cnt_en && flush_i);
    ret_d = sat_inc(ret_q, cnt_en && retire_i);
    if (clr_i) begin
      cyc_d = '0;
      stl_d = '0;
      fls_d = '0;
      ret_d = '0;
    end
  end

  assign hit = cnt_en && (XW'(cyc_d) == XW'(MAX_CYCLES));

  always_comb begin
    st_d = st_q;
    if (clr_i) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE: if (start_i) st_d = ST_RUN;
        ST_RUN: begin
          if (!start_i) st_d = ST_IDLE;
          else if (hit) st_d = ST_DONE;
        end
        ST_DONE: st_d = ST_DONE;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (sel_i)
      SEL_CYC: rd_d = cyc_d;
      SEL_STL: rd_d = stl_d;
      SEL_FLS: rd_d = fls_d;
      SEL_RET: rd_d = ret_d;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q      <= ST_IDLE;
      cyc_q     <= '0;
      stl_q     <= '0;
      fls_q     <= '0;
      ret_q     <= '0;
      rdata_o   <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cyc_q     <= cyc_d;
      stl_q     <= stl_d;
      fls_q     <= fls_d;
      ret_q     <= ret_d;
      rdata_o   <= rd_d;
      running_o <= (st_d == ST_RUN);
      done_o    <= (st_d == ST_DONE);
    end
  end

`ifdef PERF_TRACE_EN
  perf_trace_buf #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .we_i    (cnt_en && retire_i),
    .wdata_i (pc_i),
    .ridx_i  (trace_idx_i),
    .rdata_o (trace_pc_o)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{pc_i, 32'(TRACE_DEPTH)};
`endif

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of every event counter and of rdata_o.
REQ-002 Parameter MAX_CYCLES, default 80: RUN-cycle budget; reaching it ends the measurement window.
REQ-003 Parameter TRACE_DEPTH, default 8, power of two: retired-PC trace entries (only with PERF_TRACE_EN).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  level enable; high = measure, low = pause.
REQ-007 clr_i  input  1  synchronous clear of counters, trace and state.
REQ-008 stall_i  input  1  hazard-detection stall of the current cycle.
REQ-009 flush_i  input  1  branch-taken flush of the current cycle.
REQ-010 retire_i  input  1  an instruction is written back (MEM/WB valid) this cycle.
REQ-011 pc_i  input  32  PC of the retiring instruction, valid with retire_i.
REQ-012 sel_i  input  2  counter select: 0 cycles, 1 stalls, 2 flushes, 3 retired.
REQ-013 rdata_o  output  CNT_W  registered value of the selected counter.
REQ-014 running_o  output  1  high while in RUN.
REQ-015 done_o  output  1  high while in DONE.
REQ-016 trace_idx_i  input  log2(TRACE_DEPTH)  trace read index, 0 = most recent (PERF_TRACE_EN only).
REQ-017 trace_pc_o  output  32  registered trace entry at trace_idx_i (PERF_TRACE_EN only).

Function
REQ-018 States IDLE, RUN, DONE; IDLE->RUN on start_i=1; RUN->IDLE on start_i=0 with counters held; RUN->DONE on the cycle the cycle counter reaches MAX_CYCLES; DONE left only via clr_i or reset.
REQ-019 Events are counted only in RUN, including the cycle in which RUN->DONE is taken; no event counting in IDLE or DONE.
REQ-020 Cycle counter +1 per RUN cycle; stall counter +1 when stall_i=1 and flush_i=0; flush counter +1 when flush_i=1; retired counter +1 when retire_i=1.
REQ-021 stall_i and flush_i both high in one cycle: flush counted, stall not counted.
REQ-022 Every counter saturates at 2^CNT_W-1; no wrap-around.
REQ-023 clr_i=1: all counters and trace zero, state IDLE next cycle; clr_i dominates start_i and all events of the same cycle.
REQ-024 rdata_o = counter selected by sel_i, sampled one cycle earlier (1-cycle latency), reflecting the counter value after that edge's update.
REQ-025 running_o and done_o are decoded directly from the state register; never both high.

Reset
REQ-026 rst_i low: state IDLE, all counters 0, rdata_o 0, running_o 0, done_o 0, trace entries and trace_pc_o 0, effective immediately regardless of clock.
REQ-027 Reset mid-RUN discards all counts; after rst_i deasserts, a new window starts on the first edge with start_i=1.

Configuration
REQ-028 Macro PERF_TRACE_EN defined: circular buffer of the last TRACE_DEPTH retired PCs (written on retire_i in RUN, write pointer wraps modulo TRACE_DEPTH), readable with 1-cycle latency via trace_idx_i/trace_pc_o.
REQ-029 PERF_TRACE_EN undefined: trace buffer, trace_idx_i and trace_pc_o absent; all other behaviour identical.

Structure
REQ-030 Shared package holds the state enum (IDLE/RUN/DONE), the sel_i encoding constants and the default CNT_W/MAX_CYCLES values.
REQ-031 Trace buffer is a separate sub-module perf_trace_buf (write enable, data, read index, registered read), instantiated only under PERF_TRACE_EN.

Verification
REQ-032 Reset released, start_i=1 for 100 cycles, no events -> done_o rises after RUN cycle 80; cycles counter reads 80 and stays 80; running_o=0.
REQ-033 In RUN: stall_i=1 for 3 cycles, flush_i=1 for 2 cycles, then both high for 1 cycle -> stalls=3, flushes=3.
REQ-034 start_i low for 10 cycles after 20 RUN cycles, then high -> cycles counter holds 20 during the pause, then resumes at 21.
REQ-035 CNT_W=4, retire_i held high for 20 RUN cycles -> retired reads 15 (saturated).
REQ-036 clr_i and stall_i both high in RUN with stalls=5 -> stalls=0, state IDLE next cycle; rst_i pulsed low mid-RUN -> all outputs 0 immediately.
REQ-037 PERF_TRACE_EN, TRACE_DEPTH=8: retire PCs 0,4,...,40 (11 entries) -> trace_idx_i 0 returns 40, index 7 returns 12.
